fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Instruction-fetch stage of the WISC-SP20 five-stage pipeline, sitting directly upstream of the IF/ID pipeline register. Owns the program counter and the request/ready handshake with instruction memory or cache. Selects the next PC from sequential increment, EX-stage redirect, or halt/stall hold. Drives the fetched instruction, PC+2, a misalignment flag and a memory-stall flag into IF/ID.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSN, 16'h0800, instruction word driven when no valid fetch data exists
- TRAP_VECTOR, 16'h0002, misalignment trap target (used only with FETCH_MISALIGN_TRAP_EN)

- clk  input  1  pipeline clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- stall_fetch  input  1  decode hazard stall; hold the PC
- halt_detect  input  1  HALT decoded; stop fetching
- redirect_valid  input  1  EX-stage branch/jump/RTI taken
- redirect_target  input  16  new PC when redirect_valid=1
- imem_req  output  1  fetch request valid
- imem_addr  output  16  fetch address (equals pc)
- imem_rdata  input  16  fetch data, valid when imem_ready=1
- imem_ready  input  1  memory completes the current request this cycle
- instruction  output  16  to IF/ID instruction input
- incremented_pc  output  16  pc+2, to IF/ID
- inst_mis_align  output  1  pc[0]=1 for the current fetch
- stall_ins_mem  output  1  no valid instruction this cycle because memory is busy
- halted  output  1  fetch is permanently stopped
- epc  output  16  faulting PC (FETCH_MISALIGN_TRAP_EN only; otherwise tied to 16'h0000)

## Operation
- State register values: RUN, WAIT, FLUSH, HALTED. The state is held with the 16-bit pc and the 16-bit pend_target.
- incremented_pc = pc + 16'd2, modulo 2^16 (16'hFFFE wraps to 16'h0000). imem_addr = pc at all times.
- RUN:
  - If pc[0]=0: imem_req=1.
  - If imem_ready=1: instruction=imem_rdata, stall_ins_mem=0, and pc <= pc+2 unless stall_fetch=1.
  - If imem_ready=0: instruction=NOP_INSN, stall_ins_mem=1, next state WAIT.
- WAIT:
  - imem_req=1 and imem_addr is held stable.
  - The memory ready path behaves as in RUN, then the block returns to RUN.
- Redirect priority: redirect > halt_detect > stall_fetch > sequential.
  - In RUN, or in WAIT with imem_ready=1: pc <= redirect_target and state becomes RUN. The same-cycle instruction is still presented; flushing it is the job of IF/ID.
  - In WAIT with imem_ready=0: pend_target <= redirect_target and state becomes FLUSH.
- FLUSH:
  - imem_req=1 with the old address; the block waits for the outstanding response.
  - When imem_ready=1, the response is discarded: instruction=NOP_INSN, stall_ins_mem=1, pc <= pend_target, state becomes RUN.
  - A new redirect_valid during FLUSH overwrites pend_target.
- halt_detect=1 without redirect_valid: enter HALTED once no request is outstanding (immediately from RUN; from WAIT, when imem_ready arrives).
- HALTED: imem_req=0, instruction=NOP_INSN, stall_ins_mem=1, halted=1, pc frozen. Only reset leaves this state.
- Misaligned pc (pc[0]=1):
  - imem_req=0, instruction=NOP_INSN, inst_mis_align=1, stall_ins_mem=0.
  - The PC update follows the Configuration section.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - pc=RESET_PC, state=RUN, pend_target=0, epc=0.
  - imem_req=0, halted=0, instruction=NOP_INSN, incremented_pc=RESET_PC+2, inst_mis_align=0, stall_ins_mem=0.
- First request: in the first clk cycle after rst_n rises, imem_addr=RESET_PC and imem_req=1.
- Throughput: one instruction per cycle on zero-wait memory. Each wait cycle adds one stall_ins_mem=1 cycle.
- Redirect-to-fetch latency:
  - RUN: imem_addr=redirect_target in the cycle after redirect_valid.
  - FLUSH: imem_addr=redirect_target in the cycle after the discarded response.
- All outputs except the registered ones (pc, state, epc) are combinational from state, pc and the memory inputs.
- Reset asserted mid-WAIT or mid-FLUSH: the outstanding request is abandoned and the block returns to the reset values immediately.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A misaligned fetch sets epc <= pc and pc <= TRAP_VECTOR on the next edge, regardless of stall_fetch.
  - redirect_valid in the same cycle takes priority over the trap, and epc is not written.
- FETCH_MISALIGN_TRAP_EN undefined:
  - pc holds while misaligned, until a redirect arrives. inst_mis_align stays 1 each cycle.
  - epc is tied to 16'h0000.

## Test plan
- Reset release with imem_ready=1 and imem_rdata=16'h4005 → imem_addr goes 0000, 0002, 0004 on consecutive cycles; instruction=16'h4005; stall_ins_mem=0.
- imem_ready low for 2 cycles at pc=0x0010 → stall_ins_mem=1 for 2 cycles; imem_addr held at 0x0010; then instruction is valid and pc becomes 0x0012.
- Redirect to 0x0100 while WAIT at 0x0020, ready after 3 cycles → discarded response driven as NOP with stall_ins_mem=1; next imem_addr=0x0100.
- halt_detect with pc=0x0030 and no redirect → halted=1 and imem_req=0 from the next cycle. Holds for 10 cycles; only rst_n=0 clears it.
- redirect_target=0x0041 → inst_mis_align=1, imem_req=0, instruction=0x0800. With the macro: epc=0x0041 and imem_addr=0x0002 next cycle. Without the macro: pc stays 0x0041.
- stall_fetch=1 and redirect_valid=1 (target 0x0200) in the same cycle → pc=0x0200 next cycle; redirect wins.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch bus between fetch_pc_unit (master) and the
// instruction memory or cache (slave).
interface fetch_pc_unit_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC and the request/ready handshake with
// instruction memory, and feeds instruction / pc+2 / status flags to IF/ID.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned fetch traps to
// TRAP_VECTOR and records the faulting PC in epc; otherwise pc holds and
// epc is tied to zero).
module fetch_pc_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] NOP_INSN    = 16'h0800
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   parameter logic [15:0] TRAP_VECTOR = 16'h0002
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall_fetch,
   input  logic                   halt_detect,
   input  logic                   redirect_valid,
   input  logic [15:0]            redirect_target,
   fetch_pc_unit_if.master        imem,
   output logic [15:0]            instruction,
   output logic [15:0]            incremented_pc,
   output logic                   inst_mis_align,
   output logic                   stall_ins_mem,
   output logic                   halted,
   output logic [15:0]            epc
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      WAIT   = 2'd1,
      FLUSH  = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] pc_reg, pc_next;
   logic [15:0] pend_target_reg, pend_target_next;
   logic        misaligned;

   assign misaligned = pc_reg[0];

`ifdef FETCH_MISALIGN_TRAP_EN
   logic [15:0] epc_reg, epc_next;
   assign epc = epc_reg;
`else
   assign epc = 16'h0000;
`endif

   // Next-state / next-PC selection: redirect > halt > (trap) > wait > stall > sequential.
   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      pend_target_next = pend_target_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
      epc_next         = epc_reg;
`endif
      case (state_reg)
         RUN: begin
            if (redirect_valid) begin
               pc_next = redirect_target;
            end else if (halt_detect) begin
               state_next = HALTED;
            end else if (misaligned) begin
`ifdef FETCH_MISALIGN_TRAP_EN
               epc_next = pc_reg;
               pc_next  = TRAP_VECTOR;
`endif
            end else if (!imem.imem_ready) begin
               state_next = WAIT;
            end else if (!stall_fetch) begin
               pc_next = pc_reg + 16'd2;
            end
         end
         WAIT: begin
            if (imem.imem_ready) begin
               state_next = RUN;
               if (redirect_valid) begin
                  pc_next = redirect_target;
               end else if (halt_detect) begin
                  state_next = HALTED;
               end else if (!stall_fetch) begin
                  pc_next = pc_reg + 16'd2;
               end
            end else if (redirect_valid) begin
               // The in-flight response belongs to the wrong path; park the target.
               pend_target_next = redirect_target;
               state_next       = FLUSH;
            end
         end
         FLUSH: begin
            if (imem.imem_ready) begin
               state_next = RUN;
               pc_next    = redirect_valid ? redirect_target : pend_target_reg;
            end else if (redirect_valid) begin
               pend_target_next = redirect_target;
            end
         end
         default: begin
            // HALTED: frozen until reset.
         end
      endcase
   end

   // State, PC and pending-target registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= RUN;
         pc_reg          <= RESET_PC;
         pend_target_reg <= 16'h0000;
`ifdef FETCH_MISALIGN_TRAP_EN
         epc_reg         <= 16'h0000;
`endif
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         pend_target_reg <= pend_target_next;
`ifdef FETCH_MISALIGN_TRAP_EN
         epc_reg         <= epc_next;
`endif
      end
   end

   // Combinational fetch outputs; forced to quiet values while reset is held.
   always_comb begin
      imem.imem_req  = 1'b0;
      instruction    = NOP_INSN;
      inst_mis_align = 1'b0;
      stall_ins_mem  = 1'b0;
      halted         = 1'b0;
      if (rst_n) begin
         case (state_reg)
            RUN: begin
               if (misaligned) begin
                  inst_mis_align = 1'b1;
               end else begin
                  imem.imem_req = 1'b1;
                  if (imem.imem_ready) instruction = imem.imem_rdata;
                  else                 stall_ins_mem = 1'b1;
               end
            end
            WAIT: begin
               imem.imem_req = 1'b1;
               if (imem.imem_ready) instruction = imem.imem_rdata;
               else                 stall_ins_mem = 1'b1;
            end
            FLUSH: begin
               imem.imem_req = 1'b1;
               stall_ins_mem = 1'b1;
            end
            default: begin
               stall_ins_mem = 1'b1;
               halted        = 1'b1;
            end
         endcase
      end
   end

   assign imem.imem_addr = pc_reg;
   assign incremented_pc = pc_reg + 16'd2;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed test-plan steps followed by
// randomized traffic, all compared every cycle against a flag-based model.
module tb_fetch_pc_unit;

   localparam logic [15:0] NOP = 16'h0800;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_fetch, halt_detect, redirect_valid;
   logic [15:0] redirect_target;
   logic [15:0] instruction, incremented_pc, epc;
   logic        inst_mis_align, stall_ins_mem, halted;

   int checks   = 0;
   int failures = 0;

   // reference model: PC plus "what is outstanding" flags
   logic [15:0] m_pc, m_pend, m_epc;
   bit          m_busy, m_drop, m_halt;

   fetch_pc_unit_if bus ();

   fetch_pc_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall_fetch     (stall_fetch),
      .halt_detect     (halt_detect),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem            (bus),
      .instruction     (instruction),
      .incremented_pc  (incremented_pc),
      .inst_mis_align  (inst_mis_align),
      .stall_ins_mem   (stall_ins_mem),
      .halted          (halted),
      .epc             (epc)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      bus.imem_ready  = 1'b1;
      bus.imem_rdata  = 16'($urandom);
      redirect_valid  = 1'b0;
      redirect_target = 16'($urandom);
      stall_fetch     = 1'b0;
      halt_detect     = 1'b0;
      #1;
      chk1("rst_req",   bus.imem_req,   1'b0);
      chk ("rst_addr",  bus.imem_addr,  16'h0000);
      chk ("rst_ins",   instruction,    NOP);
      chk ("rst_incpc", incremented_pc, 16'h0002);
      chk1("rst_mis",   inst_mis_align, 1'b0);
      chk1("rst_stall", stall_ins_mem,  1'b0);
      chk1("rst_halt",  halted,         1'b0);
      chk ("rst_epc",   epc,            16'h0000);
      m_pc = 16'h0000; m_pend = 16'h0000; m_epc = 16'h0000;
      m_busy = 0; m_drop = 0; m_halt = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance.
   task automatic step(input bit rv, input logic [15:0] rt, input bit rdy,
                       input logic [15:0] rd, input bit st, input bit hd);
      logic        e_req, e_mis, e_stall, e_halt;
      logic [15:0] e_ins;
      bit          fresh;
      redirect_valid  = rv;
      redirect_target = rt;
      bus.imem_ready  = rdy;
      bus.imem_rdata  = rd;
      stall_fetch     = st;
      halt_detect     = hd;
      #2;
      e_req = 0; e_mis = 0; e_stall = 0; e_halt = 0; e_ins = NOP;
      fresh = !m_halt && !m_drop && !m_busy;
      if (m_halt) begin
         e_stall = 1; e_halt = 1;
      end else if (m_drop) begin
         e_req = 1; e_stall = 1;
      end else if (fresh && m_pc[0]) begin
         e_mis = 1;
      end else begin
         e_req = 1;
         if (rdy) e_ins = rd;
         else     e_stall = 1;
      end
      chk1("req",   bus.imem_req,   e_req);
      chk ("addr",  bus.imem_addr,  m_pc);
      chk ("ins",   instruction,    e_ins);
      chk ("incpc", incremented_pc, m_pc + 16'd2);
      chk1("mis",   inst_mis_align, e_mis);
      chk1("stall", stall_ins_mem,  e_stall);
      chk1("halt",  halted,         e_halt);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk ("epc",   epc,            m_epc);
`else
      chk ("epc",   epc,            16'h0000);
`endif
      @(posedge clk);
      #1;
      if (m_halt) begin
         // frozen
      end else if (m_drop) begin
         if (rdy) begin
            m_pc = rv ? rt : m_pend;
            m_drop = 0;
         end else if (rv) begin
            m_pend = rt;
         end
      end else if (m_busy && !rdy) begin
         if (rv) begin
            m_pend = rt; m_drop = 1; m_busy = 0;
         end
      end else begin
         if (rv) begin
            m_pc = rt; m_busy = 0;
         end else if (hd) begin
            m_halt = 1;
         end else if (fresh && m_pc[0]) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            m_epc = m_pc;
            m_pc  = 16'h0002;
`endif
         end else if (!rdy) begin
            m_busy = 1;
         end else begin
            m_busy = 0;
            if (!st) m_pc = m_pc + 16'd2;
         end
      end
   endtask

   initial begin
      logic [15:0] rt;
      rst_n = 1'b1;
      redirect_valid = 0; redirect_target = 0; stall_fetch = 0; halt_detect = 0;
      bus.imem_ready = 0; bus.imem_rdata = 0;
      #1;
      do_reset();

      // sequential fetch after reset
      step(0, 16'h0000, 1, 16'h4005, 0, 0);
      chk("seq_addr1", bus.imem_addr, 16'h0002);
      step(0, 16'h0000, 1, 16'h4005, 0, 0);
      chk("seq_addr2", bus.imem_addr, 16'h0004);

      // two wait cycles at 0x0010
      step(1, 16'h0010, 1, 16'h1234, 0, 0);
      step(0, 16'h0000, 0, 16'hDEAD, 0, 0);
      step(0, 16'h0000, 0, 16'hBEEF, 0, 0);
      chk("wait_hold", bus.imem_addr, 16'h0010);
      step(0, 16'h0000, 1, 16'h5A5A, 0, 0);
      chk("wait_done", bus.imem_addr, 16'h0012);

      // redirect during WAIT, response three cycles later is discarded
      step(1, 16'h0020, 1, 16'h1111, 0, 0);
      step(0, 16'h0000, 0, 16'h2222, 0, 0);
      step(1, 16'h0100, 0, 16'h3333, 0, 0);
      step(0, 16'h0000, 0, 16'h4444, 0, 0);
      step(0, 16'h0000, 1, 16'h5555, 0, 0);
      chk("flush_target", bus.imem_addr, 16'h0100);

      // redirect beats stall
      step(1, 16'h0200, 1, 16'h6666, 1, 0);
      chk("redir_over_stall", bus.imem_addr, 16'h0200);

      // misaligned target
      step(1, 16'h0041, 1, 16'h7777, 0, 0);
      chk1("mis_flag", inst_mis_align, 1'b1);
      chk1("mis_noreq", bus.imem_req, 1'b0);
      chk ("mis_nop", instruction, NOP);
      step(0, 16'h0000, 1, 16'h8888, 1, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("trap_epc",  epc, 16'h0041);
      chk("trap_addr", bus.imem_addr, 16'h0002);
`else
      chk("mis_hold", bus.imem_addr, 16'h0041);
      step(0, 16'h0000, 1, 16'h8888, 0, 0);
`endif
      step(1, 16'h0030, 1, 16'h9999, 0, 0);

      // halt at 0x0030, held for 10 cycles
      step(0, 16'h0000, 1, 16'hAAAA, 0, 1);
      chk1("halt_now", halted, 1'b1);
      for (int i = 0; i < 10; i++)
         step(bit'($urandom), 16'($urandom), bit'($urandom), 16'($urandom),
              bit'($urandom), bit'($urandom));
      chk1("halt_sticky", halted, 1'b1);
      chk ("halt_pc", bus.imem_addr, 16'h0030);
      do_reset();
      chk1("halt_cleared", halted, 1'b0);

      // reset mid-WAIT and mid-FLUSH
      step(0, 16'h0000, 0, 16'h0101, 0, 0);
      do_reset();
      step(0, 16'h0000, 0, 16'h0202, 0, 0);
      step(1, 16'h0300, 0, 16'h0303, 0, 0);
      do_reset();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ((m_halt && ($urandom_range(0, 7) == 0)) || ($urandom_range(0, 299) == 0)) begin
            do_reset();
         end else begin
            rt = 16'($urandom);
            if ($urandom_range(0, 3) != 0) rt[0] = 1'b0;
            step($urandom_range(0, 7) == 0, rt, $urandom_range(0, 3) != 0,
                 16'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 63) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
